// File: rtl/piho_pkg.sv
// Shared constants and types for the PIHO measurement stage.
package piho_pkg;

    localparam int unsigned FRAC   = 16;
    localparam int unsigned DATA_W = 32;
    localparam logic [DATA_W-1:0] ONE = 32'h0001_0000;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SQ_W   = PROD_W - FRAC;
    localparam int unsigned SUM_W  = 64;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_MEASURE,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/piho_sq_acc.sv
// Two-stage square/shift then saturating accumulate of Q16.16 samples.
module piho_sq_acc
    import piho_pkg::*;
#(
    parameter int unsigned ACC_W = SUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              sat_o
);

    localparam int unsigned ADD_W = ACC_W + 1;

    logic signed [PROD_W-1:0] ext_c;
    logic        [PROD_W-1:0] prod_c;
    logic        [ADD_W-1:0]  add_c;

    logic             sq_vld_q, sq_vld_d;
    logic [SQ_W-1:0]  sq_q, sq_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    // The square of any signed 32-bit value is non-negative and fits 64 bits.
    always_comb begin
        ext_c    = PROD_W'($signed(data_i));
        prod_c   = PROD_W'(ext_c * ext_c);
        sq_vld_d = en_i;
        sq_d     = SQ_W'(prod_c >> FRAC);
        add_c    = {1'b0, sum_q} + ADD_W'(sq_q);
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        if (sq_vld_q) begin
            if (add_c[ACC_W]) begin
                sum_d = '1;
                sat_d = 1'b1;
            end else begin
                sum_d = add_c[ACC_W-1:0];
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (clr_i) begin
            sq_vld_d = 1'b0;
            sq_d     = '0;
            sum_d    = '0;
            cnt_d    = '0;
            sat_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sq_vld_q <= 1'b0;
            sq_q     <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            sq_vld_q <= sq_vld_d;
            sq_q     <= sq_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
        end
    end

    assign sum_o = sum_q;
    assign cnt_o = cnt_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/piho_meas.sv
// Sweep-counting measurement FSM: skips warm-up sweeps, accumulates sum of x^2, holds the result.
module piho_meas
    import piho_pkg::*;
#(
    parameter int unsigned SITES = 64,
    parameter int unsigned ACC_W = SUM_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        warmupskip,
    input  logic [CNT_W-1:0]        totalsweeps,
    input  logic                    sample_valid,
    input  logic [DATA_W-1:0]       sample_data,
    input  logic                    sample_last,
    output logic                    busy,
    output logic [CNT_W-1:0]        sweep_cnt,
    output logic [SUM_W-1:0]        x2sum,
    output logic [CNT_W-1:0]        nsamples,
    output logic                    sat,
    output logic                    err_len,
    output logic                    result_valid,
    input  logic                    result_ready
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  warm_q, warm_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CNT_W-1:0]  sweep_q, sweep_d;
    logic [CNT_W-1:0]  site_q, site_d;
    logic              err_q, err_d;
    logic [1:0]        drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              rv_q, rv_d;
    logic              in_vld_q, in_vld_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic              clr_c;
    logic [CNT_W-1:0]  sweep_nxt_c;
    logic [CNT_W-1:0]  site_inc_c;
    logic [ACC_W-1:0]  acc_sum;

    always_comb begin
        state_d     = state_q;
        warm_d      = warm_q;
        total_d     = total_q;
        sweep_d     = sweep_q;
        site_d      = site_q;
        err_d       = err_q;
        drain_d     = drain_q;
        clr_c       = 1'b0;
        sweep_nxt_c = sweep_q + CNT_W'(1);
        site_inc_c  = site_q + CNT_W'(1);
        in_vld_d    = sample_valid && (state_q == ST_MEASURE);
        in_data_d   = sample_data;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    warm_d  = warmupskip;
                    total_d = totalsweeps;
                    sweep_d = '0;
                    site_d  = '0;
                    err_d   = 1'b0;
                    drain_d = '0;
                    clr_c   = 1'b1;
                    if (totalsweeps == '0) begin
                        state_d = ST_DRAIN;
                    end else if (warmupskip == '0) begin
                        state_d = ST_MEASURE;
                    end else begin
                        state_d = ST_WARMUP;
                    end
                end
            end
            ST_WARMUP, ST_MEASURE: begin
                if (sample_valid) begin
                    site_d = site_inc_c;
                    if (sample_last) begin
                        site_d  = '0;
                        sweep_d = sweep_nxt_c;
                        if (site_inc_c != CNT_W'(SITES)) begin
                            err_d = 1'b1;
                        end
                        // Reaching the total wins over leaving warm-up.
                        if (sweep_nxt_c == total_q) begin
                            state_d = ST_DRAIN;
                            drain_d = '0;
                        end else if ((state_q == ST_WARMUP) && (sweep_nxt_c == warm_q)
                                     && (warm_q < total_q)) begin
                            state_d = ST_MEASURE;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'd2) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_WARMUP) || (state_d == ST_MEASURE) || (state_d == ST_DRAIN);
        rv_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            warm_q    <= '0;
            total_q   <= '0;
            sweep_q   <= '0;
            site_q    <= '0;
            err_q     <= 1'b0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            rv_q      <= 1'b0;
            in_vld_q  <= 1'b0;
            in_data_q <= '0;
        end else begin
            state_q   <= state_d;
            warm_q    <= warm_d;
            total_q   <= total_d;
            sweep_q   <= sweep_d;
            site_q    <= site_d;
            err_q     <= err_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            rv_q      <= rv_d;
            in_vld_q  <= in_vld_d;
            in_data_q <= in_data_d;
        end
    end

    piho_sq_acc #(
        .ACC_W (ACC_W)
    ) u_sq_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr_c),
        .en_i   (in_vld_q),
        .data_i (in_data_q),
        .sum_o  (acc_sum),
        .cnt_o  (nsamples),
        .sat_o  (sat)
    );

    assign x2sum        = SUM_W'(acc_sum);
    assign busy         = busy_q;
    assign sweep_cnt    = sweep_q;
    assign err_len      = err_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_piho_meas.sv
// Directed bench for piho_meas with a sweep-level reference model and per-cycle compare.
module tb_piho_meas;
    import piho_pkg::*;

    localparam int unsigned TB_SITES = 64;
    // Narrow accumulator so saturation is reachable in a few hundred cycles.
    localparam int unsigned TB_ACC_W = 53;

    localparam int M_IDLE = 0, M_WARM = 1, M_MEAS = 2, M_DRAIN = 3, M_DONE = 4;

    logic        clk, rst_n, start, sample_valid, sample_last, result_ready;
    logic [31:0] warmupskip, totalsweeps, sample_data;
    logic        busy, sat, err_len, result_valid;
    logic [31:0] sweep_cnt, nsamples;
    logic [63:0] x2sum;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    piho_meas #(.SITES(TB_SITES), .ACC_W(TB_ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .warmupskip(warmupskip), .totalsweeps(totalsweeps),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_last(sample_last),
        .busy(busy), .sweep_cnt(sweep_cnt), .x2sum(x2sum), .nsamples(nsamples),
        .sat(sat), .err_len(err_len), .result_valid(result_valid), .result_ready(result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mode = M_IDLE;
    longint      cyc = 0;
    longint      m_done_at = 0;
    int unsigned m_w = 0, m_t = 0, m_sweeps = 0, m_sites = 0, m_n = 0;
    bit          m_err = 0;
    logic [127:0] m_sum = '0;
    logic [127:0] max_v;

    function automatic logic [127:0] sq_q16(input logic [31:0] d);
        longint          x;
        longint unsigned p;
        x = longint'($signed(d));
        p = longint'(x * x);
        return 128'(p >> 16);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_mode = M_IDLE; m_sweeps = 0; m_sites = 0; m_err = 0; m_sum = '0; m_n = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_w = warmupskip; m_t = totalsweeps;
                    m_sweeps = 0; m_sites = 0; m_err = 0; m_sum = '0; m_n = 0;
                    if (m_t == 0) begin m_mode = M_DRAIN; m_done_at = cyc + 3; end
                    else if (m_w == 0) m_mode = M_MEAS;
                    else m_mode = M_WARM;
                end
                M_WARM, M_MEAS: if (sample_valid) begin
                    if (m_mode == M_MEAS) begin
                        m_sum = m_sum + sq_q16(sample_data);
                        m_n++;
                    end
                    m_sites++;
                    if (sample_last) begin
                        if (m_sites != TB_SITES) m_err = 1;
                        m_sites = 0;
                        m_sweeps++;
                        if (m_sweeps == m_t) begin m_mode = M_DRAIN; m_done_at = cyc + 3; end
                        else if (m_sweeps == m_w) m_mode = M_MEAS;
                    end
                end
                M_DRAIN: if (cyc == m_done_at) m_mode = M_DONE;
                M_DONE:  if (result_ready) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison; result fields are final only in DONE and while held in IDLE.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_busy", 64'(busy), 64'((m_mode == M_WARM) || (m_mode == M_MEAS) || (m_mode == M_DRAIN)));
            chk("cmp_result_valid", 64'(result_valid), 64'(m_mode == M_DONE));
            chk("cmp_sweep_cnt", 64'(sweep_cnt), 64'(m_sweeps));
            chk("cmp_err_len", 64'(err_len), 64'(m_err));
            if (m_mode == M_IDLE || m_mode == M_DONE) begin
                chk("cmp_x2sum", x2sum, 64'((m_sum > max_v) ? max_v : m_sum));
                chk("cmp_sat", 64'(sat), 64'(m_sum > max_v));
                chk("cmp_nsamples", 64'(nsamples), 64'(m_n));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        sample_valid = v; sample_data = d; sample_last = l;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sample_valid = 1'b0; sample_data = '0; sample_last = 1'b0; start = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] w, input logic [31:0] t);
        warmupskip = w; totalsweeps = t; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sweep(input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) drive(1'b1, d, (i == n - 1));
    endtask

    task automatic wait_rv(input string name, output int n);
        n = 0;
        while (!result_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) chk({name, "_timeout"}, 64'(result_valid), 64'd1);
    endtask

    task automatic ack();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("ack_rv_drop", 64'(result_valid), 64'd0);
        chk("ack_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        max_v = (128'd1 << TB_ACC_W) - 128'd1;
        rst_n = 1'b0; result_ready = 1'b0; warmupskip = '0; totalsweeps = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_x2sum", x2sum, 64'd0);
        chk("rst_rv", 64'(result_valid), 64'd0);
        chk("rst_nsamples", 64'(nsamples), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Warm-up 1, total 3, all 1.0
        do_start(32'd1, 32'd3);
        chk("A_busy_after_start", 64'(busy), 64'd1);
        repeat (3) sweep(TB_SITES, ONE);
        idle_inputs();
        wait_rv("A", n);
        chk("A_last_to_rv", 64'(n), 64'd3);
        chk("A_x2sum", x2sum, 64'h80_0000);
        chk("A_nsamples", 64'(nsamples), 64'd128);
        chk("A_sweep_cnt", 64'(sweep_cnt), 64'd3);
        chk("A_sat", 64'(sat), 64'd0);
        chk("A_err", 64'(err_len), 64'd0);
        ack();

        // Zero total sweeps
        do_start(32'd0, 32'd0);
        wait_rv("B0", n);
        chk("B0_start_to_rv", 64'(n), 64'd3);
        chk("B0_x2sum", x2sum, 64'd0);
        chk("B0_nsamples", 64'(nsamples), 64'd0);
        ack();

        // Warm-up exceeds total
        do_start(32'd5, 32'd2);
        repeat (2) sweep(TB_SITES, ONE);
        idle_inputs();
        wait_rv("B1", n);
        chk("B1_x2sum", x2sum, 64'd0);
        chk("B1_sweep_cnt", 64'(sweep_cnt), 64'd2);
        chk("B1_nsamples", 64'(nsamples), 64'd0);
        ack();

        // Most-negative input until saturation
        do_start(32'd0, 32'd3);
        repeat (3) sweep(TB_SITES, 32'h8000_0000);
        idle_inputs();
        wait_rv("C", n);
        chk("C_sat", 64'(sat), 64'd1);
        chk("C_x2sum", x2sum, 64'h001F_FFFF_FFFF_FFFF);
        chk("C_nsamples", 64'(nsamples), 64'd192);
        ack();

        // Short sweep, then a normal one with accumulation latency pinned
        do_start(32'd0, 32'd2);
        sweep(TB_SITES - 1, ONE);
        chk("D_err_len", 64'(err_len), 64'd1);
        chk("D_sweep_cnt", 64'(sweep_cnt), 64'd1);
        repeat (3) drive(1'b0, '0, 1'b0);
        drive(1'b1, 32'h0002_0000, 1'b0);
        chk("D_lat_t0", x2sum, 64'h3F_0000);
        drive(1'b1, '0, 1'b0);
        chk("D_lat_t1", x2sum, 64'h3F_0000);
        drive(1'b1, '0, 1'b0);
        chk("D_lat_t2", x2sum, 64'h43_0000);
        for (int i = 0; i < 61; i++) drive(1'b1, '0, (i == 60));
        idle_inputs();
        wait_rv("D", n);
        chk("D_x2sum", x2sum, 64'h43_0000);
        chk("D_nsamples", 64'(nsamples), 64'd127);

        // DONE ignores start and samples while the host stalls
        for (int i = 0; i < 10; i++) begin
            start = i[0]; warmupskip = '0; totalsweeps = 32'd1;
            drive(1'b1, $urandom, i[1]);
        end
        idle_inputs();
        chk("E_rv_held", 64'(result_valid), 64'd1);
        chk("E_x2sum_held", x2sum, 64'h43_0000);
        chk("E_sweep_held", 64'(sweep_cnt), 64'd2);
        ack();
        chk("E_x2sum_idle", x2sum, 64'h43_0000);

        // Reset mid-measure, then a fresh run of 0.5
        do_start(32'd0, 32'd2);
        repeat (10) drive(1'b1, ONE, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        chk("F_rst_busy", 64'(busy), 64'd0);
        chk("F_rst_x2sum", x2sum, 64'd0);
        chk("F_rst_nsamples", 64'(nsamples), 64'd0);
        chk("F_rst_sweep", 64'(sweep_cnt), 64'd0);
        chk("F_rst_rv", 64'(result_valid), 64'd0);
        @(negedge clk);
        do_start(32'd0, 32'd1);
        sweep(TB_SITES, 32'h0000_8000);
        idle_inputs();
        wait_rv("F", n);
        chk("F_x2sum", x2sum, 64'h10_0000);
        chk("F_nsamples", 64'(nsamples), 64'd64);
        chk("F_err", 64'(err_len), 64'd0);
        ack();

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piho_meas.md
# piho_meas

Measurement stage directly downstream of the PIHO unit's buffer-write pipeline. It consumes the per-site accept/reject stream (one Q16.16 lattice coordinate per cycle, one sweep of SITES values per half-lattice update), discards the first `warmupskip` sweeps, then accumulates Σx² over the measured sweeps. A finished run is presented to the host readout as a held result with a valid/ready handshake.

## Interface
- `SITES`, 64: samples per sweep; must be a power of two, ≥2.
- `FRAC`, 16: fractional bits of the sample format (Q16.16).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches config and begins a run (honoured only in IDLE).
- `warmupskip`  in  32  sweeps discarded before measuring; sampled on `start`.
- `totalsweeps`  in  32  total sweeps in the run, warm-up included; sampled on `start`.
- `sample_valid`  in  1  `sample_data` is valid this cycle.
- `sample_data`  in  32  signed Q16.16 site value.
- `sample_last`  in  1  qualifies the final sample of a sweep; meaningful only with `sample_valid`.
- `busy`  out  1  high in WARMUP, MEASURE and DRAIN.
- `sweep_cnt`  out  32  sweeps completed in the current run.
- `x2sum`  out  64  accumulated Σ(x²>>FRAC), unsigned.
- `nsamples`  out  32  number of samples accumulated.
- `sat`  out  1  `x2sum` saturated during the run (sticky).
- `err_len`  out  1  a sweep ended with a sample count ≠ SITES (sticky).
- `result_valid`  out  1  result outputs are stable and final.
- `result_ready`  in  1  host has taken the result.

## Operation
- States: IDLE → (start) → WARMUP or MEASURE → DRAIN → DONE → (result_valid∧result_ready) → IDLE.
- On `start` in IDLE: latch the config. Clear `sweep_cnt`, `x2sum`, `nsamples`, `sat`, `err_len` and the per-sweep site counter.
  - `totalsweeps`==0 → DRAIN directly.
  - `warmupskip`==0 → MEASURE.
  - otherwise → WARMUP.
- Per-sweep site counter: 32 bits. It increments on each valid sample and is cleared on `sample_last`. If the count including the last sample is ≠ SITES, set `err_len`. The sweep is still counted.
- On a valid `sample_last`, `sweep_cnt` increments.
  - WARMUP → MEASURE when the new `sweep_cnt` == `warmupskip`, provided `warmupskip` < `totalsweeps`.
  - Any state → DRAIN when the new `sweep_cnt` == `totalsweeps`. This takes priority, so `warmupskip` ≥ `totalsweeps` goes straight to DRAIN and gives `x2sum`=0.
- Only samples accepted in MEASURE enter the datapath. Samples in IDLE, DRAIN and DONE are ignored; samples in WARMUP are counted only.
- Datapath:
  - Stage 1: p = signed(sample_data)² as a 64-bit unsigned value (always fits), then q = p >> FRAC, a 48-bit Q32.16 value.
  - Stage 2: `x2sum` += q, saturating at 2⁶⁴−1 and setting `sat`. `nsamples` += 1, saturating at 2³²−1.
  - Most-negative input 0x80000000 → p = 2⁶², which is legal.
- DRAIN waits 2 cycles for the pipeline to empty, then enters DONE.
- In DONE, `result_valid`=1 and all result outputs are held. A `start` in DONE is ignored.
- `rst_n`=0 at any time, including mid-run or mid-handshake: all state returns to IDLE and the pipeline is flushed, with no partial result.

## Timing
- Reset values: `busy`=0, `sweep_cnt`=0, `x2sum`=0, `nsamples`=0, `sat`=0, `err_len`=0, `result_valid`=0, state IDLE.
- `start` at edge T → `busy`=1 from T+1. A sample at T+1 is processed.
- A sample accepted at edge T is reflected in `x2sum` after edge T+2.
- The final `sample_last` accepted at edge T → `result_valid`=1 after edge T+3. At that point `busy`=0 and `x2sum` includes that last sample.
- Result handshake completes on the edge where `result_valid` and `result_ready` are both high. `result_valid` drops the next cycle. The outputs keep their values in IDLE until the next `start`.
- No backpressure: the block accepts one sample per cycle, back-to-back without limit.

## Structure
- Shared package `piho_pkg`: Q16.16 constants (`FRAC`=16, ONE=32'h00010000), the state enum (IDLE, WARMUP, MEASURE, DRAIN, DONE), and the 64-bit saturating-add width constants.
- One sub-module, `piho_sq_acc`: the 2-stage square-shift-accumulate pipeline with saturation. It has clear and enable inputs. The FSM and counters stay in the top.

## Test plan
- warmupskip=1, totalsweeps=3, SITES=64, every sample 0x00010000 (1.0) → `x2sum`=128·0x10000=0x800000, `nsamples`=128, `sweep_cnt`=3, `sat`=0, `err_len`=0.
- totalsweeps=0, `start` → `result_valid` 3 cycles after `start` with all results 0. warmupskip=5, totalsweeps=2 → 2 sweeps consumed, `x2sum`=0.
- Samples 0x80000000 (−32768.0) for 2 measured sweeps, then more until the sum exceeds 2⁶⁴ → `sat`=1 and `x2sum`=0xFFFF_FFFF_FFFF_FFFF held in DONE.
- Sweep closed with `sample_last` after 63 samples → `err_len`=1 and `sweep_cnt` still increments. The next 64-sample sweep is accumulated normally.
- Hold `result_ready`=0 for 10 cycles in DONE, toggle `start` and drive samples → outputs unchanged. Raise `result_ready` → IDLE next cycle.
- Assert `rst_n`=0 mid-MEASURE for 1 cycle → all outputs at reset values next cycle. A new run then gives the expected fresh sum.
